// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (load/store over fetch) arbiter onto one shared memory port.
// One transaction in flight; a transaction exceeding TIMEOUT cycles is aborted with zero data.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_wen_i,
  input  logic [31:0] ls_addr_i,
  input  logic [63:0] ls_wdata_i,
  input  logic [7:0]  ls_wmask_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [63:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_wmask_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        timeout_err_o
);
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_ls_q, own_ls_d;
  logic          wen_q, wen_d;
  logic [31:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic          terr_q, terr_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [63:0]   ls_rdata_q, ls_rdata_d;
  logic          tmo, gnt, done, abort;
  logic [63:0]   rsp;
  // cnt_q holds the number of REQ/WAIT cycles already completed, so tmo marks the TIMEOUT-th cycle
  assign tmo = cnt_q >= TMO_LAST;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    own_ls_d = own_ls_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    gnt      = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: if (ls_req_i || if_req_i) begin
        state_d  = REQ;
        cnt_d    = '0;
        own_ls_d = ls_req_i;
        wen_d    = ls_req_i & ls_wen_i;
        addr_d   = ls_req_i ? ls_addr_i : if_addr_i;
        wdata_d  = ls_req_i ? ls_wdata_i : '0;
        wmask_d  = ls_req_i ? ls_wmask_i : '0;
      end
      REQ: begin
        cnt_d   = cnt_q + 1'b1;
        gnt     = mem_ready_i;
        abort   = !mem_ready_i && tmo;
        state_d = mem_ready_i ? WAIT : (tmo ? IDLE : REQ);
      end
      WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        done    = mem_rvalid_i;
        abort   = !mem_rvalid_i && tmo;
        state_d = (mem_rvalid_i || tmo) ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    rsp         = abort ? '0 : mem_rdata_i;
    if_rvalid_d = (done || abort) && !own_ls_q;
    ls_rvalid_d = (done || abort) && own_ls_q;
    terr_d      = abort;
    if_rdata_d  = if_rvalid_d ? (addr_q[2] ? rsp[63:32] : rsp[31:0]) : if_rdata_q;
    ls_rdata_d  = ls_rvalid_d ? rsp : ls_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_ls_q    <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      terr_q      <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_ls_q    <= own_ls_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      terr_q      <= terr_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end
  assign if_gnt_o      = gnt & ~own_ls_q;
  assign ls_gnt_o      = gnt & own_ls_q;
  assign if_rvalid_o   = if_rvalid_q;
  assign ls_rvalid_o   = ls_rvalid_q;
  assign if_rdata_o    = if_rdata_q;
  assign ls_rdata_o    = ls_rdata_q;
  assign timeout_err_o = terr_q;
  assign mem_req_o     = state_q == REQ;
  assign mem_wen_o     = wen_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_wmask_o   = wmask_q;
endmodule
